// File: rtl/clkdiv_bank.sv
// -----------------------------------------------------------------------------
// clkdiv_bank
//
// Purpose:
//    Bank of NUM_CH independent integer clock-enable dividers that all run on
//    one clock. Channel i produces a one-cycle strobe on ce_out[i] once every
//    P = max(D[i],1) cycles, where D[i] is its programmable divide ratio.
//    After reset the outputs stay idle until a start-up settle count of
//    LOCK_CYCLES edges has elapsed. After that, locked goes high and the
//    enabled channels start counting.
//
// Optional feature:
//    CLKDIV_BANK_PHASE_EN  when defined, adds output ph_out. ph_out[i] toggles
//                          on every ce_out[i] strobe, so it is a square wave
//                          with period 2P.
//
// Ports:
//    sys_clk  in   1       block clock, all logic on the rising edge
//    sys_rst  in   1       synchronous active-high reset
//    cfg_we   in   1       divide-ratio write strobe
//    cfg_ch   in   CH_W    channel addressed by the write (out-of-range ignored)
//    cfg_div  in   DIV_W   new divide ratio
//    ch_en    in   NUM_CH  per-channel run enable
//    sync     in   1       restart all channel counters together
//    ph_out   out  NUM_CH  per-channel half-rate phase (CLKDIV_BANK_PHASE_EN only)
//    ce_out   out  NUM_CH  per-channel registered one-cycle clock-enable strobe
//    locked   out  1       registered, high once start-up count has completed
// -----------------------------------------------------------------------------
module clkdiv_bank #(
   parameter int NUM_CH      = 4,
   parameter int DIV_W       = 16,
   parameter int DIV_INIT    = 2,
   parameter int LOCK_CYCLES = 256,
   localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              sys_clk,
   input  logic              sys_rst,
   input  logic              cfg_we,
   input  logic [CH_W-1:0]   cfg_ch,
   input  logic [DIV_W-1:0]  cfg_div,
   input  logic [NUM_CH-1:0] ch_en,
   input  logic              sync,
`ifdef CLKDIV_BANK_PHASE_EN
   output logic [NUM_CH-1:0] ph_out,
`endif
   output logic [NUM_CH-1:0] ce_out,
   output logic              locked
);

   // Lock counter is wide enough to hold LOCK_CYCLES-1 for any legal value.
   localparam int               LK_W    = $clog2(LOCK_CYCLES + 1);
   localparam logic [LK_W-1:0]  LK_LAST = LK_W'(LOCK_CYCLES - 1);
   localparam logic [DIV_W-1:0] DIV_RST = DIV_W'(DIV_INIT);

   // Last counter value of a period: P-1 with P = max(D,1).
   // Ratios 0 and 1 both give 0, so the channel strobes every cycle.
   function automatic logic [DIV_W-1:0] period_last(input logic [DIV_W-1:0] div);
      logic [DIV_W-1:0] last;
      if (div == {DIV_W{1'b0}}) begin
         last = {DIV_W{1'b0}};
      end else begin
         last = div - DIV_W'(1);
      end
      return last;
   endfunction

   // ---------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------
   logic                r_locked;
   logic [LK_W-1:0]     r_lock_cnt;
   logic [DIV_W-1:0]    r_div [NUM_CH];
   logic [DIV_W-1:0]    r_cnt [NUM_CH];
   logic [NUM_CH-1:0]   r_ce;

   // ---------------------------------------------------------------------
   // Next-state nets
   // ---------------------------------------------------------------------
   logic                w_locked_nxt;
   logic [LK_W-1:0]     w_lock_cnt_nxt;
   logic [DIV_W-1:0]    w_div_nxt [NUM_CH];
   logic [DIV_W-1:0]    w_cnt_nxt [NUM_CH];
   logic [DIV_W-1:0]    w_last    [NUM_CH];
   logic [NUM_CH-1:0]   w_ce_nxt;
   logic [NUM_CH-1:0]   w_wr_sel;
   logic [NUM_CH-1:0]   w_clr;
   logic                w_cfg_hit;

   // A write to a channel number that does not exist is dropped entirely.
   assign w_cfg_hit = cfg_we && (32'(cfg_ch) < NUM_CH);

   // Lock sequencer: count edges since reset, then latch locked until next reset
   always_comb begin
      w_lock_cnt_nxt = r_lock_cnt;
      w_locked_nxt   = r_locked;
      if (r_locked) begin
         w_lock_cnt_nxt = r_lock_cnt;
         w_locked_nxt   = 1'b1;
      end else if (r_lock_cnt == LK_LAST) begin
         w_lock_cnt_nxt = r_lock_cnt;
         w_locked_nxt   = 1'b1;
      end else begin
         w_lock_cnt_nxt = r_lock_cnt + LK_W'(1);
         w_locked_nxt   = 1'b0;
      end
   end

   // Per-channel period end value and write decode
   always_comb begin
      w_wr_sel = {NUM_CH{1'b0}};
      for (int i = 0; i < NUM_CH; i++) begin
         w_last[i] = period_last(r_div[i]);
         if (w_cfg_hit && (32'(cfg_ch) == i)) begin
            w_wr_sel[i] = 1'b1;
         end else begin
            w_wr_sel[i] = 1'b0;
         end
      end
   end

   // Per-channel divider: ratio update, counter advance/wrap and strobe decode
   always_comb begin
      w_ce_nxt = {NUM_CH{1'b0}};
      w_clr    = {NUM_CH{1'b0}};
      for (int i = 0; i < NUM_CH; i++) begin
         w_div_nxt[i] = r_div[i];
         w_cnt_nxt[i] = r_cnt[i];

         if (w_wr_sel[i]) begin
            w_div_nxt[i] = cfg_div;
         end else begin
            w_div_nxt[i] = r_div[i];
         end

         // Any restart condition parks the counter at 0 and blocks the
         // strobe. A freshly written channel therefore starts a full new
         // period with the new ratio.
         w_clr[i] = sync || w_wr_sel[i] || !r_locked || !ch_en[i];

         if (w_clr[i]) begin
            w_cnt_nxt[i] = {DIV_W{1'b0}};
            w_ce_nxt[i]  = 1'b0;
         end else if (r_cnt[i] >= w_last[i]) begin
            // >= rather than == so a counter can never run past the end.
            w_cnt_nxt[i] = {DIV_W{1'b0}};
            w_ce_nxt[i]  = 1'b1;
         end else begin
            w_cnt_nxt[i] = r_cnt[i] + DIV_W'(1);
            w_ce_nxt[i]  = 1'b0;
         end
      end
   end

   // State registers with synchronous reset taking priority over all inputs
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         r_locked   <= 1'b0;
         r_lock_cnt <= {LK_W{1'b0}};
         r_ce       <= {NUM_CH{1'b0}};
         for (int i = 0; i < NUM_CH; i++) begin
            r_div[i] <= DIV_RST;
            r_cnt[i] <= {DIV_W{1'b0}};
         end
      end else begin
         r_locked   <= w_locked_nxt;
         r_lock_cnt <= w_lock_cnt_nxt;
         r_ce       <= w_ce_nxt;
         for (int i = 0; i < NUM_CH; i++) begin
            r_div[i] <= w_div_nxt[i];
            r_cnt[i] <= w_cnt_nxt[i];
         end
      end
   end

`ifdef CLKDIV_BANK_PHASE_EN
   logic [NUM_CH-1:0] r_ph;
   logic [NUM_CH-1:0] w_ph_nxt;

   // Phase next state: toggle with each strobe, park low whenever the channel is idle
   always_comb begin
      w_ph_nxt = r_ph;
      for (int i = 0; i < NUM_CH; i++) begin
         if (sync || !r_locked || !ch_en[i]) begin
            w_ph_nxt[i] = 1'b0;
         end else begin
            w_ph_nxt[i] = r_ph[i] ^ w_ce_nxt[i];
         end
      end
   end

   // Phase register
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         r_ph <= {NUM_CH{1'b0}};
      end else begin
         r_ph <= w_ph_nxt;
      end
   end

   assign ph_out = r_ph;
`endif

   assign ce_out = r_ce;
   assign locked = r_locked;

endmodule
